// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//
// Contents:
//   uart_state_e : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   par_typ_e    : parity type encoding (EVEN = 0, ODD = 1)
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    typedef enum logic {
        ParEven = 1'b0,
        ParOdd  = 1'b1
    } par_typ_e;

endpackage

// File: rtl/parity_calc.sv
// Parity bit generator for a UART frame.
//
// Ports:
//   data    : payload whose parity is computed
//   par_typ : parity type (ParEven / ParOdd)
//   parity  : bit that makes the total count of ones even (ParEven) or odd (ParOdd)
module parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    always_comb begin
        parity = (^data) ^ (par_typ == ParOdd);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one DATA_WIDTH payload per frame, one bit per clk cycle.
// Frame: start (0), data LSB first, optional parity, stop (1).
//
// Ports:
//   clk        : baud-rate clock
//   ARSTn      : asynchronous active-low reset
//   P_DATA     : parallel payload, latched on accept
//   DATA_VALID : frame request; accepted in IDLE or during the STOP cycle
//   PAR_EN     : append a parity bit (latched on accept)
//   PAR_TYP    : 0 = even, 1 = odd parity (latched on accept)
//   TX_OUT     : registered serial line, idle high
//   Busy       : registered, high while a frame is on the line
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned        CntWidth = $clog2(DATA_WIDTH + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  parity_bit;
    logic                  data_bit;

    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (parity_bit)
    );

    // A new frame may start from idle, or directly after the stop bit of the
    // current one so back-to-back frames carry no idle gap.
    assign accept = DATA_VALID && ((state_q == StIdle) || (state_q == StStop));

    // State, counter, latches and registered outputs all share one edge.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= ParEven;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                state_d = accept ? StStart : StIdle;
            end
            default: begin
                // Illegal encoding: fall back to idle on the next edge.
                state_d = StIdle;
            end
        endcase
    end

    // Serializer mux: select latched data bit addressed by the next counter value.
    always_comb begin
        data_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (cnt_d == CntWidth'(i)) begin
                data_bit = data_q[i];
            end
        end
    end

    // Output logic, evaluated on the next state so outputs register with the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        unique case (state_d)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            StStart: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            StData: begin
                tx_d   = data_bit;
                busy_d = 1'b1;
            end
            StParity: begin
                tx_d   = parity_bit;
                busy_d = 1'b1;
            end
            StStop: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          ARSTn;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          Busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .ARSTn      (ARSTn),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the line and Busy.
    task automatic cyc(input string tag, input logic exp_tx, input logic exp_busy);
        @(negedge clk);
        check($sformatf("%s_tx", tag), {7'b0, TX_OUT}, {7'b0, exp_tx});
        check($sformatf("%s_busy", tag), {7'b0, Busy}, {7'b0, exp_busy});
    endtask

    // Expected line value k cycles into a frame; pbit is the hand-computed parity.
    function automatic logic fbit(input logic [7:0] d, input logic pen, input logic pbit,
                                  input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && pen) return pbit;
        return 1'b1;
    endfunction

    initial begin
        logic       exp_a5 [10];
        logic [7:0] b;
        logic [7:0] rx;
        logic       pen;
        logic       ptyp;
        logic       pb;

        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        ARSTn      = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        cyc("rst0", 1'b1, 1'b0);
        cyc("rst1", 1'b1, 1'b0);

        // Release reset and request on the very first edge: 0xA5, no parity.
        ARSTn      = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("a5_k%0d", k), exp_a5[k], 1'b1);
            if (k == 0) DATA_VALID = 1'b0;
        end
        cyc("a5_idle", 1'b1, 1'b0);

        // 0x07 even parity -> parity bit 1; inputs scrambled after accept.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h07;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        for (int k = 0; k < 11; k++) begin
            cyc($sformatf("pe_k%0d", k), fbit(8'h07, 1'b1, 1'b1, k), 1'b1);
            if (k == 0) begin
                DATA_VALID = 1'b0;
                P_DATA     = 8'hF8;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b1;
            end
        end
        cyc("pe_idle", 1'b1, 1'b0);

        // 0x07 odd parity -> parity bit 0.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h07;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        for (int k = 0; k < 11; k++) begin
            cyc($sformatf("po_k%0d", k), fbit(8'h07, 1'b1, 1'b0, k), 1'b1);
            if (k == 0) begin
                DATA_VALID = 1'b0;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b0;
            end
        end
        cyc("po_idle", 1'b1, 1'b0);

        // DATA_VALID held: 0x3C then 0xC3 switched in the first STOP cycle.
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h3C;
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("b2b1_k%0d", k), fbit(8'h3C, 1'b0, 1'b0, k), 1'b1);
            if (k == 9) P_DATA = 8'hC3;
        end
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("b2b2_k%0d", k), fbit(8'hC3, 1'b0, 1'b0, k), 1'b1);
            if (k == 0) DATA_VALID = 1'b0;
        end
        cyc("b2b_idle0", 1'b1, 1'b0);
        cyc("b2b_idle1", 1'b1, 1'b0);

        // Request pulsed mid-DATA with new data: must be ignored entirely.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("ign_k%0d", k), fbit(8'h5A, 1'b0, 1'b0, k), 1'b1);
            if (k == 0) DATA_VALID = 1'b0;
            if (k == 3) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
            end
            if (k == 4) DATA_VALID = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("ign_idle%0d", k), 1'b1, 1'b0);
        end

        // Reset pulsed during the 4th data bit of 0x96.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h96;
        for (int k = 0; k <= 4; k++) begin
            cyc($sformatf("ar_k%0d", k), fbit(8'h96, 1'b0, 1'b0, k), 1'b1);
            if (k == 0) DATA_VALID = 1'b0;
        end
        #2 ARSTn = 1'b0;
        #1;
        check("ar_async_tx", {7'b0, TX_OUT}, 8'h01);
        check("ar_async_busy", {7'b0, Busy}, 8'h00);
        @(negedge clk);
        ARSTn = 1'b1;
        cyc("ar_idle0", 1'b1, 1'b0);
        cyc("ar_idle1", 1'b1, 1'b0);
        // 0x3D has five ones, odd parity -> parity bit 0.
        DATA_VALID = 1'b1;
        P_DATA     = 8'h3D;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        for (int k = 0; k < 11; k++) begin
            cyc($sformatf("ar2_k%0d", k), fbit(8'h3D, 1'b1, 1'b0, k), 1'b1);
            if (k == 0) DATA_VALID = 1'b0;
        end
        cyc("ar2_idle", 1'b1, 1'b0);

        // Random bytes through a bench receiver, all parity combinations.
        for (int i = 0; i < 256; i++) begin
            b          = 8'($urandom_range(0, 255));
            pen        = i[0];
            ptyp       = i[1];
            DATA_VALID = 1'b1;
            P_DATA     = b;
            PAR_EN     = pen;
            PAR_TYP    = ptyp;
            @(negedge clk);
            check($sformatf("rx%0d_start", i), {7'b0, TX_OUT}, 8'h00);
            DATA_VALID = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                rx[j] = TX_OUT;
            end
            if (pen) begin
                @(negedge clk);
                pb = TX_OUT;
                check($sformatf("rx%0d_par", i), {7'b0, pb}, {7'b0, (^rx) ^ ptyp});
            end
            @(negedge clk);
            check($sformatf("rx%0d_stop", i), {7'b0, TX_OUT}, 8'h01);
            check($sformatf("rx%0d_data", i), rx, b);
        end
        cyc("rx_idle", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
